// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module     : control_sequencer
// Description: Multi-cycle fetch/decode/execute/memory/writeback control FSM
//              that drives the datapath enables for a single-issue CPU.
//              Define INSTR_COUNT_EN to add the retired-instruction counter
//              and its instr_count port.
// Revision   : 1.0
// ============================================================================
module control_sequencer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        branch_taken,
    output logic        imem_read,
    output logic        ir_load,
    output logic        pc_enable,
    output logic        pc_src,
    output logic        rf_write_enable,
    output logic        dmem_read_enable,
    output logic        dmem_write_enable,
    output logic        halted,
    output logic        fault,
`ifdef INSTR_COUNT_EN
    output logic [2:0]  state,
    output logic [31:0] instr_count
`else
    output logic [2:0]  state
`endif
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5,
        S_FAULT     = 3'd6,
        S_UNUSED    = 3'd7
    } state_t;

    localparam logic [7:0] c_MEM_TIMEOUT = 8'(MEM_TIMEOUT);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_mem_cnt;
    logic [7:0] w_cnt_next;

    logic [5:0] w_op;
    logic       w_is_mem;
    logic       w_is_branch;
    logic       w_unused;

    logic w_imem_read, w_ir_load, w_pc_enable, w_pc_src, w_rf_we;
    logic w_dmem_rd, w_dmem_wr, w_halted, w_fault;

    assign w_op        = instruction[31:26];
    assign w_is_mem    = (w_op >= 6'd24) && (w_op <= 6'd27);
    assign w_is_branch = (w_op >= 6'd28);
    assign w_unused    = ^instruction[25:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_mem_cnt <= 8'd0;
        end else begin
            r_state   <= w_next;
            r_mem_cnt <= w_cnt_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_cnt_next  = r_mem_cnt;
        w_imem_read = 1'b0;
        w_ir_load   = 1'b0;
        w_pc_enable = 1'b0;
        w_pc_src    = 1'b0;
        w_rf_we     = 1'b0;
        w_dmem_rd   = 1'b0;
        w_dmem_wr   = 1'b0;
        w_halted    = 1'b0;
        w_fault     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_imem_read = 1'b1;
                if (imem_ready) begin
                    w_ir_load = 1'b1;
                    w_next    = S_DECODE;
                end
            end
            S_DECODE: begin
                w_next = (w_op == 6'd0) ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                if (w_is_mem) begin
                    w_next     = S_MEMORY;
                    w_cnt_next = 8'd0;
                end else if (w_is_branch) begin
                    w_pc_enable = 1'b1;
                    w_pc_src    = branch_taken;
                    w_next      = S_FETCH;
                end else begin
                    w_next = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                w_dmem_rd = ~w_op[0];
                w_dmem_wr = w_op[0];
                // A completing access takes priority over the timeout check.
                if (dmem_ready) begin
                    if (w_op[0]) begin
                        w_pc_enable = 1'b1;
                        w_next      = S_FETCH;
                    end else begin
                        w_next = S_WRITEBACK;
                    end
                end else if (r_mem_cnt == c_MEM_TIMEOUT) begin
                    w_next = S_FAULT;
                end else begin
                    w_cnt_next = r_mem_cnt + 8'd1;
                end
            end
            S_WRITEBACK: begin
                w_rf_we     = 1'b1;
                w_pc_enable = 1'b1;
                w_next      = S_FETCH;
            end
            S_HALT:  w_halted = 1'b1;
            S_FAULT: w_fault  = 1'b1;
            default: w_next   = S_FETCH;
        endcase
    end

    // Reset aborts the instruction in flight: no side-effecting enable may fire.
    assign imem_read         = w_imem_read;
    assign ir_load           = w_ir_load   & ~rst;
    assign pc_enable         = w_pc_enable & ~rst;
    assign pc_src            = w_pc_src    & ~rst;
    assign rf_write_enable   = w_rf_we     & ~rst;
    assign dmem_read_enable  = w_dmem_rd   & ~rst;
    assign dmem_write_enable = w_dmem_wr   & ~rst;
    assign halted            = w_halted;
    assign fault             = w_fault;
    assign state             = r_state;

`ifdef INSTR_COUNT_EN
    logic [31:0] r_instr_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_count <= 32'd0;
        end else if (pc_enable) begin
            r_instr_count <= r_instr_count + 32'd1;
        end
    end

    assign instr_count = r_instr_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module     : tb_control_sequencer
// Description: Randomized instruction-stream bench for control_sequencer,
//              checked against a per-instruction phase trace model.
// Revision   : 1.0
// ============================================================================
module tb_control_sequencer;

    localparam int MEM_TIMEOUT = 15;
    localparam int N_INSTR     = 300;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction;
    logic        imem_ready, dmem_ready, branch_taken;
    logic        imem_read, ir_load, pc_enable, pc_src, rf_write_enable;
    logic        dmem_read_enable, dmem_write_enable, halted, fault;
    logic [2:0]  state;
`ifdef INSTR_COUNT_EN
    logic [31:0] instr_count;
`endif

    always #5 clk = ~clk;

    control_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_dut (
        .clk               (clk),
        .rst               (rst),
        .instruction       (instruction),
        .imem_ready        (imem_ready),
        .dmem_ready        (dmem_ready),
        .branch_taken      (branch_taken),
        .imem_read         (imem_read),
        .ir_load           (ir_load),
        .pc_enable         (pc_enable),
        .pc_src            (pc_src),
        .rf_write_enable   (rf_write_enable),
        .dmem_read_enable  (dmem_read_enable),
        .dmem_write_enable (dmem_write_enable),
        .halted            (halted),
        .fault             (fault),
`ifdef INSTR_COUNT_EN
        .state             (state),
        .instr_count       (instr_count)
`else
        .state             (state)
`endif
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_cnt = 32'd0;
    bit          m_cnt_ok = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output word: {imem_read, ir_load, pc_en, pc_src, rf_we, drd, dwr, halted, fault, state}
    function automatic logic [11:0] ex(input logic [2:0] st, input logic imr, irl, pce, pcs,
                                       rfw, drd, dwr, hlt, flt);
        return {imr, irl, pce, pcs, rfw, drd, dwr, hlt, flt, st};
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic cyc(input logic r, ir, dr, bt, input logic [11:0] e, input bit do_chk);
        rst = r; imem_ready = ir; dmem_ready = dr; branch_taken = bt;
        @(negedge clk);
        if (do_chk)
            chk("outputs", 32'({imem_read, ir_load, pc_enable, pc_src, rf_write_enable,
                                dmem_read_enable, dmem_write_enable, halted, fault, state}),
                32'(e));
`ifdef INSTR_COUNT_EN
        if (m_cnt_ok) chk("instr_count", instr_count, m_cnt);
`endif
        @(posedge clk);
        #1;
        if (r) begin
            m_cnt    = 32'd0;
            m_cnt_ok = 1'b1;
        end else if (e[9]) begin
            m_cnt = m_cnt + 32'd1;
        end
    endtask

    // Two reset cycles; the first still shows the pre-reset state with enables suppressed.
    task automatic do_reset(input logic [11:0] cur, input bit known);
        cyc(1'b1, rb(), rb(), rb(), cur, known);
        cyc(1'b1, rb(), rb(), rb(), ex(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    endtask

    // Drives one instruction through the core; returns 1 if it ended in HALT or FAULT.
    task automatic run_instr(input logic [5:0] op, input int wi, input int wd,
                             input logic bt, output bit stopped, output logic [11:0] last);
        logic st;
        stopped = 1'b0;
        st = op[0];
        instruction = {op, 26'($urandom)};
        for (int k = 0; k < wi; k++)
            cyc(0, 0, rb(), rb(), ex(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1);
        cyc(0, 1, rb(), rb(), ex(3'd0, 1, 1, 0, 0, 0, 0, 0, 0, 0), 1);
        cyc(0, rb(), rb(), rb(), ex(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
        last = ex(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        if (op == 6'd0) begin
            last = ex(3'd5, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            for (int k = 0; k < 4; k++) cyc(0, rb(), rb(), rb(), last, 1);
            stopped = 1'b1;
        end else if (op >= 6'd28) begin
            cyc(0, rb(), rb(), bt, ex(3'd2, 0, 0, 1, bt, 0, 0, 0, 0, 0), 1);
        end else if (op < 6'd24) begin
            cyc(0, rb(), rb(), rb(), ex(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
            cyc(0, rb(), rb(), rb(), ex(3'd4, 0, 0, 1, 0, 1, 0, 0, 0, 0), 1);
        end else begin
            cyc(0, rb(), rb(), rb(), ex(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
            for (int k = 0; k <= MEM_TIMEOUT; k++) begin
                if (k == wd) begin
                    cyc(0, rb(), 1, rb(), ex(3'd3, 0, 0, st, 0, 0, ~st, st, 0, 0), 1);
                    if (!st)
                        cyc(0, rb(), rb(), rb(), ex(3'd4, 0, 0, 1, 0, 1, 0, 0, 0, 0), 1);
                    break;
                end
                cyc(0, rb(), 0, rb(), ex(3'd3, 0, 0, 0, 0, 0, ~st, st, 0, 0), 1);
                if (k == MEM_TIMEOUT) begin
                    last = ex(3'd6, 0, 0, 0, 0, 0, 0, 0, 0, 1);
                    for (int j = 0; j < 4; j++) cyc(0, rb(), rb(), rb(), last, 1);
                    stopped = 1'b1;
                end
            end
        end
    endtask

    initial begin
        bit          stopped;
        logic [11:0] last;
        logic [5:0]  op;
        int          wi, wd, sel;
        rst = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
        instruction = 32'd0;
        @(posedge clk);
        #1;
        do_reset(12'd0, 1'b0);

        // Store aborted by reset in the very cycle its memory access completes.
        instruction = {6'd25, 26'd0};
        cyc(0, 1, 0, 0, ex(3'd0, 1, 1, 0, 0, 0, 0, 0, 0, 0), 1);
        cyc(0, 0, 0, 0, ex(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
        cyc(0, 0, 0, 0, ex(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
        cyc(1, 0, 1, 0, ex(3'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
        cyc(0, 0, 0, 0, ex(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1);

        for (int n = 0; n < N_INSTR; n++) begin
            sel = int'($urandom_range(0, 99));
            op  = (sel < 4) ? 6'd0 : 6'($urandom_range(1, 63));
            if (sel >= 4 && sel < 30) op = 6'($urandom_range(24, 27));
            wi  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      wd = MEM_TIMEOUT;
            else if (sel == 1) wd = MEM_TIMEOUT + 1;
            else               wd = int'($urandom_range(0, 4));
            run_instr(op, wi, wd, rb(), stopped, last);
            if (stopped) do_reset(last, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
